// File: rtl/clahe_pkg.sv
// rtl/clahe_pkg.sv - shared constants and FSM state type for the CLAHE tile LUT builder
package clahe_pkg;

  localparam int CLAHE_BINS          = 256;
  localparam int CLAHE_PIXEL_W       = 8;
  localparam int CLAHE_TILE_PIX_LOG2 = 10;
  localparam int CLAHE_CLIP_LIMIT    = 20;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    ACCUM,
    CLIP,
    EMIT
  } clahe_lut_state_e;

endpackage

// File: rtl/clahe_hist_ram.sv
// rtl/clahe_hist_ram.sv - histogram bin array, async read port, one write port with same-address forwarding
module clahe_hist_ram #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic              pend_en;
  logic [ADDR_W-1:0] pend_addr;
  logic [DATA_W-1:0] pend_data;

  // Writes land one cycle late; the pending entry is forwarded so a read always sees the newest value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend_en <= 1'b0;
    else        pend_en <= wr_en;
  end

  always_ff @(posedge clk) begin
    pend_addr <= wr_addr;
    pend_data <= wr_data;
    if (pend_en) mem[pend_addr] <= pend_data;
  end

  assign rd_data = (pend_en && (pend_addr == rd_addr)) ? pend_data : mem[rd_addr];

endmodule

// File: rtl/clahe_tile_lut_gen.sv
// rtl/clahe_tile_lut_gen.sv - per-tile CLAHE histogram, clip/redistribute and CDF LUT streamer
// Optional CLAHE_LUT_ROUND_EN: round-to-nearest normalization instead of truncation.
module clahe_tile_lut_gen
  import clahe_pkg::*;
#(
  parameter int PIXEL_W       = CLAHE_PIXEL_W,
  parameter int TILE_PIX_LOG2 = CLAHE_TILE_PIX_LOG2,
  parameter int CLIP_LIMIT    = CLAHE_CLIP_LIMIT,
  parameter int HIST_W        = TILE_PIX_LOG2 + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               pix_valid,
  output logic               pix_ready,
  input  logic [PIXEL_W-1:0] pix_data,
  output logic               lut_valid,
  input  logic               lut_ready,
  output logic [7:0]         lut_idx,
  output logic [PIXEL_W-1:0] lut_data,
  output logic [HIST_W-1:0]  excess,
  output logic               busy,
  output logic               done
);

  localparam int PW = HIST_W + 8;
  localparam logic [HIST_W-1:0] CLIP_V = HIST_W'(CLIP_LIMIT);
`ifdef CLAHE_LUT_ROUND_EN
  localparam logic [PW-1:0] RND = PW'(1) << (TILE_PIX_LOG2 - 1);
`else
  localparam logic [PW-1:0] RND = '0;
`endif

  clahe_lut_state_e         state, state_n;
  logic [7:0]               cnt;
  logic [TILE_PIX_LOG2-1:0] beat_cnt;
  logic [HIST_W-1:0]        cdf, excess_q;
  logic                     done_q;

  logic [7:0]               rd_addr, wr_addr;
  logic [HIST_W-1:0]        rd_data, wr_data;
  logic                     wr_en;

  logic [HIST_W-1:0]        perbin, h, cdf_n;
  logic [7:0]               rem;
  logic [PW-1:0]            prod, scaled;
  logic [PIXEL_W-1:0]       scaled_sat;

  clahe_hist_ram #(.ADDR_W(8), .DATA_W(HIST_W)) u_hist (
    .clk     (clk),
    .rst_n   (rst_n),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data)
  );

  // Redistributed excess is folded in per entry rather than written back into the bins.
  always_comb begin
    perbin     = excess_q >> 8;
    rem        = excess_q[7:0];
    h          = rd_data + perbin + HIST_W'(cnt < rem);
    cdf_n      = cdf + h;
    prod       = PW'(cdf_n) * PW'(255) + RND;
    scaled     = prod >> TILE_PIX_LOG2;
    scaled_sat = (scaled > PW'(2**PIXEL_W - 1)) ? '1 : scaled[PIXEL_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n   = state;
    rd_addr   = cnt;
    wr_addr   = cnt;
    wr_data   = '0;
    wr_en     = 1'b0;
    pix_ready = 1'b0;
    lut_valid = 1'b0;
    case (state)
      IDLE: if (start) state_n = CLEAR;
      CLEAR: begin
        wr_en = 1'b1;
        if (cnt == 8'hff) state_n = ACCUM;
      end
      ACCUM: begin
        pix_ready = 1'b1;
        rd_addr   = pix_data;
        wr_addr   = pix_data;
        wr_data   = rd_data + HIST_W'(1);
        wr_en     = pix_valid;
        if (pix_valid && (&beat_cnt)) state_n = CLIP;
      end
      CLIP: begin
        wr_data = CLIP_V;
        wr_en   = (rd_data > CLIP_V);
        if (cnt == 8'hff) state_n = EMIT;
      end
      EMIT: begin
        lut_valid = 1'b1;
        if (lut_ready && (cnt == 8'hff)) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      beat_cnt <= '0;
      cdf      <= '0;
      excess_q <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: if (start) begin
          cnt      <= '0;
          beat_cnt <= '0;
          cdf      <= '0;
          excess_q <= '0;
        end
        CLEAR: cnt <= cnt + 8'd1;
        ACCUM: if (pix_valid) beat_cnt <= beat_cnt + TILE_PIX_LOG2'(1);
        CLIP: begin
          cnt <= cnt + 8'd1;
          if (rd_data > CLIP_V) excess_q <= excess_q + rd_data - CLIP_V;
        end
        EMIT: if (lut_ready) begin
          cnt <= cnt + 8'd1;
          cdf <= cdf_n;
          if (cnt == 8'hff) done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign lut_idx  = (state == EMIT) ? cnt : 8'd0;
  assign lut_data = (state == EMIT) ? scaled_sat : '0;
  assign excess   = excess_q;
  assign busy     = (state != IDLE);
  assign done     = done_q;

endmodule
